// File: rtl/sa_cache_ctrl.sv
// sa_cache_ctrl: round-robin front end for the 4-way sa_cache.
// Serialises two requesters, writes back victims, refills and replays misses.
module sa_cache_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rq0_valid,
    input  logic [31:0] rq0_addr,
    input  logic        rq0_we,
    input  logic [31:0] rq0_wdata,
    input  logic        rq1_valid,
    input  logic [31:0] rq1_addr,
    input  logic        rq1_we,
    input  logic [31:0] rq1_wdata,
    output logic        rq0_ready,
    output logic        rq1_ready,
    output logic        rq0_done,
    output logic        rq1_done,
    output logic [31:0] rq_rdata,
    output logic        rq_err,
    output logic [17:0] c_tag,
    output logic [7:0]  c_index,
    output logic [5:0]  c_offset,
    output logic [31:0] c_dataW,
    output logic        c_memRW,
    output logic [31:0] c_memory_line,
    output logic        c_memory_response,
    input  logic [31:0] c_data,
    input  logic        c_miss,
    input  logic        c_evict,
    input  logic [31:0] c_evict_addr,
    input  logic [31:0] c_evict_data,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic [15:0] miss_count
);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, CHECK, WB, FILL, REFILL
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic        last_q;
    logic        port_q;
    logic [1:0]  ready_q;
    logic [1:0]  done_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [17:0] tag_q;
    logic [7:0]  index_q;
    logic [5:0]  offset_q;
    logic [31:0] dataw_q;
    logic        memrw_q;
    logic [31:0] line_q;
    logic        resp_q;
    logic        mreq_q;
    logic        mwe_q;
    logic [31:0] maddr_q;
    logic [31:0] mwdata_q;
    logic [7:0]  wait_q;
    logic [15:0] miss_q;

    logic        gnt_d;
    logic [31:0] sel_addr_d;
    logic        sel_we_d;
    logic [31:0] sel_wdata_d;
    logic [31:0] fill_addr_d;

    // With both ports pending the one not served last wins.
    always_comb begin
        gnt_d       = (rq0_valid && rq1_valid) ? ~last_q : rq1_valid;
        sel_addr_d  = gnt_d ? rq1_addr  : rq0_addr;
        sel_we_d    = gnt_d ? rq1_we    : rq0_we;
        sel_wdata_d = gnt_d ? rq1_wdata : rq0_wdata;
        fill_addr_d = {tag_q, index_q, 6'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            port_q   <= 1'b0;
            ready_q  <= 2'b00;
            done_q   <= 2'b00;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tag_q    <= '0;
            index_q  <= '0;
            offset_q <= '0;
            dataw_q  <= '0;
            memrw_q  <= 1'b0;
            line_q   <= '0;
            resp_q   <= 1'b0;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            wait_q   <= '0;
            miss_q   <= '0;
        end else begin
            ready_q <= 2'b00;
            done_q  <= 2'b00;
            rdata_q <= '0;
            err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rq0_valid || rq1_valid) begin
                        ready_q[gnt_d] <= 1'b1;
                        port_q         <= gnt_d;
                        last_q         <= gnt_d;
                        tag_q          <= sel_addr_d[31:14];
                        index_q        <= sel_addr_d[13:6];
                        offset_q       <= sel_addr_d[5:0];
                        dataw_q        <= sel_wdata_d;
                        memrw_q        <= sel_we_d;
                        state_q        <= LOOKUP;
                    end
                end
                LOOKUP: state_q <= CHECK;
                CHECK: begin
                    if (!c_miss) begin
                        done_q[port_q] <= 1'b1;
                        rdata_q        <= memrw_q ? 32'h0 : c_data;
                        state_q        <= IDLE;
                    end else begin
                        if (miss_q != 16'hFFFF)
                            miss_q <= miss_q + 16'd1;
                        wait_q <= '0;
                        mreq_q <= 1'b1;
                        if (c_evict) begin
                            mwe_q    <= 1'b1;
                            maddr_q  <= c_evict_addr;
                            mwdata_q <= c_evict_data;
                            state_q  <= WB;
                        end else begin
                            mwe_q    <= 1'b0;
                            maddr_q  <= fill_addr_d;
                            mwdata_q <= '0;
                            state_q  <= FILL;
                        end
                    end
                end
                WB, FILL: begin
                    if (m_ack) begin
                        if (state_q == WB) begin
                            mwe_q    <= 1'b0;
                            maddr_q  <= fill_addr_d;
                            mwdata_q <= '0;
                            wait_q   <= '0;
                            state_q  <= FILL;
                        end else begin
                            mreq_q  <= 1'b0;
                            line_q  <= m_rdata;
                            resp_q  <= 1'b1;
                            state_q <= REFILL;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        // Give up: report an error and leave the cache untouched.
                        mreq_q         <= 1'b0;
                        mwe_q          <= 1'b0;
                        done_q[port_q] <= 1'b1;
                        err_q          <= 1'b1;
                        state_q        <= IDLE;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                REFILL: begin
                    resp_q  <= 1'b0;
                    state_q <= LOOKUP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rq0_ready         = ready_q[0];
    assign rq1_ready         = ready_q[1];
    assign rq0_done          = done_q[0];
    assign rq1_done          = done_q[1];
    assign rq_rdata          = rdata_q;
    assign rq_err            = err_q;
    assign c_tag             = tag_q;
    assign c_index           = index_q;
    assign c_offset          = offset_q;
    assign c_dataW           = dataw_q;
    assign c_memRW           = memrw_q;
    assign c_memory_line     = line_q;
    assign c_memory_response = resp_q;
    assign m_req             = mreq_q;
    assign m_we              = mwe_q;
    assign m_addr            = maddr_q;
    assign m_wdata           = mwdata_q;
    assign miss_count        = miss_q;

endmodule
